// File: rtl/ft600_fifo_model_pkg.sv
// Shared definitions for the FT600/601 245-mode FIFO responder model:
// the legal GPIO mode code, bus FSM encodings and oERR bit positions.
package ft600_fifo_model_pkg;

    // GPIO strap value selecting 245 synchronous FIFO mode, single channel.
    localparam logic [1:0] FT_MODE_245_1CH = 2'b00;

    // Data-bus ownership states seen from the device side.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,  // bus released, writes may be captured
        S_TURN  = 2'b01,  // one turnaround cycle after OE_N falls, still hi-Z
        S_DRIVE = 2'b10   // device drives the RX head onto the bus
    } bus_state_e;

    // Sticky error flag positions in oERR.
    localparam int ERR_WR_TXE   = 0;  // write strobe while TXE_N high
    localparam int ERR_RD_BAD   = 1;  // read strobe while not readable
    localparam int ERR_WR_OE    = 2;  // write strobe together with OE_N
    localparam int ERR_MODE     = 3;  // illegal GPIO mode
    localparam int ERR_W        = 4;

endpackage

// File: rtl/ft600_fifo_model_if.sv
// FT600 control/flag signals between the FPGA-side FIFO master and the
// device model. The bidirectional data/byte-enable bus stays on plain
// inout ports so tri-state resolution happens on ordinary nets.
interface ft600_fifo_model_if;

    logic       iOE_N;   // output enable, active low (master -> device)
    logic       iRD_N;   // read strobe, active low
    logic       iWR_N;   // write strobe, active low
    logic [1:0] iGPIO;   // mode select
    logic       oTXE_N;  // low: device can accept a write
    logic       oRXF_N;  // low: device holds at least one readable word

    modport master (
        output iOE_N, iRD_N, iWR_N, iGPIO,
        input  oTXE_N, oRXF_N
    );

    modport slave (
        input  iOE_N, iRD_N, iWR_N, iGPIO,
        output oTXE_N, oRXF_N
    );

endinterface

// File: rtl/ft600_model_fifo.sv
// Single-clock first-word-fall-through buffer with occupancy output.
// The caller guarantees push only when not full and pop only when not
// empty; o_level_next exposes the post-edge occupancy so registered
// flags can be computed without a cycle of lag.
module ft600_model_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_level,
    output logic [AW:0]   o_level_next
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Pointer and occupancy update; pointers wrap modulo DEPTH by width.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({i_push, i_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;  // idle, or push+pop cancel out
        endcase
    end

    // Pointer/level registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; emptiness is defined by the pointers, and a resettable array cannot map to RAM.
        if (i_push) mem[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata      = mem[rd_ptr_q];
    assign o_level      = level_q;
    assign o_level_next = level_d;

endmodule

// File: rtl/ft600_fifo_model.sv
// Device-side responder model of an FT600/601 in 245 synchronous FIFO
// mode, one channel. The RX buffer is filled by the host port and read
// by the FPGA master over ioDATA; the TX buffer is written by the master
// and drained by the host port. Flags are registered from the post-edge
// occupancy, so a word pushed into an empty buffer becomes visible one
// cycle later and a freed slot is writable one cycle later.
module ft600_fifo_model
    import ft600_fifo_model_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                iCLK,
    input  logic                iRESET,
    ft600_fifo_model_if.slave   ft,
    inout  wire  [DATA_W-1:0]   ioDATA,
    inout  wire  [BE_W-1:0]     ioBE,
    input  logic                iHOST_WR,
    input  logic [DATA_W-1:0]   iHOST_DATA,
    input  logic [BE_W-1:0]     iHOST_BE,
    output logic                oHOST_FULL,
    input  logic                iHOST_RD,
    output logic [DATA_W-1:0]   oHOST_DATA,
    output logic [BE_W-1:0]     oHOST_BE,
    output logic                oHOST_EMPTY,
    output logic [AW:0]         oRX_LEVEL,
    output logic [AW:0]         oTX_LEVEL,
    output logic [ERR_W-1:0]    oERR
);

    localparam int          WORD_W   = DATA_W + BE_W;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    bus_state_e         state_q, state_d;
    logic               txe_n_q, txe_n_d;
    logic               rxf_n_q, rxf_n_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               mode_err;
    logic               bus_oe;
    logic               rd_ok, rx_pop, rd_err;
    logic               wr_req, tx_push, wr_err_txe, wr_err_oe;
    logic               rx_push, tx_pop;

    logic [WORD_W-1:0]  rx_head, tx_head;
    logic [AW:0]        rx_level, rx_level_next;
    logic [AW:0]        tx_level, tx_level_next;

    // RX buffer: host -> FPGA, read over the FT600 bus.
    ft600_model_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rx_fifo (
        .clk          (iCLK),
        .rst_n        (iRESET),
        .i_push       (rx_push),
        .i_pop        (rx_pop),
        .i_wdata      ({iHOST_BE, iHOST_DATA}),
        .o_rdata      (rx_head),
        .o_level      (rx_level),
        .o_level_next (rx_level_next)
    );

    // TX buffer: FPGA -> host, written over the FT600 bus.
    ft600_model_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tx_fifo (
        .clk          (iCLK),
        .rst_n        (iRESET),
        .i_push       (tx_push),
        .i_pop        (tx_pop),
        .i_wdata      ({ioBE, ioDATA}),
        .o_rdata      (tx_head),
        .o_level      (tx_level),
        .o_level_next (tx_level_next)
    );

    // Strobe qualification: decide pops, pushes and error events for this edge.
    always_comb begin
        mode_err   = (ft.iGPIO != FT_MODE_245_1CH);
        bus_oe     = (state_q == S_DRIVE);

        rd_ok      = bus_oe && !rxf_n_q;
        rx_pop     = !ft.iRD_N && rd_ok;
        rd_err     = !ft.iRD_N && !rd_ok;

        wr_req     = !ft.iWR_N;
        tx_push    = wr_req && !txe_n_q && (state_q == S_IDLE) && ft.iOE_N;
        wr_err_txe = wr_req && txe_n_q;
        wr_err_oe  = wr_req && !ft.iOE_N;

        // Host side silently ignores requests it cannot honour.
        rx_push    = iHOST_WR && !oHOST_FULL;
        tx_pop     = iHOST_RD && !oHOST_EMPTY;
    end

    // Bus FSM next state, post-edge flags and sticky error accumulation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!ft.iOE_N) state_d = S_TURN;
            S_TURN:  state_d = ft.iOE_N ? S_IDLE : S_DRIVE;
            S_DRIVE: if (ft.iOE_N) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rxf_n_d = (rx_level_next == '0) || mode_err;
        txe_n_d = (tx_level_next == LVL_FULL) || mode_err;

        err_d = err_q;
        if (wr_err_txe) err_d[ERR_WR_TXE] = 1'b1;
        if (rd_err)     err_d[ERR_RD_BAD] = 1'b1;
        if (wr_err_oe)  err_d[ERR_WR_OE]  = 1'b1;
        if (mode_err)   err_d[ERR_MODE]   = 1'b1;
    end

    // Control registers; reset releases the bus at once and raises both flags.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
            txe_n_q <= 1'b1;
            rxf_n_q <= 1'b1;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            txe_n_q <= txe_n_d;
            rxf_n_q <= rxf_n_d;
            err_q   <= err_d;
        end
    end

    // Device drives the RX head only while it owns the bus.
    assign ioDATA = bus_oe ? rx_head[DATA_W-1:0]      : {DATA_W{1'bz}};
    assign ioBE   = bus_oe ? rx_head[WORD_W-1:DATA_W] : {BE_W{1'bz}};

    assign ft.oTXE_N   = txe_n_q;
    assign ft.oRXF_N   = rxf_n_q;

    assign oHOST_FULL  = (rx_level == LVL_FULL);
    assign oHOST_EMPTY = (tx_level == '0);
    assign oHOST_DATA  = tx_head[DATA_W-1:0];
    assign oHOST_BE    = tx_head[WORD_W-1:DATA_W];
    assign oRX_LEVEL   = rx_level;
    assign oTX_LEVEL   = tx_level;
    assign oERR        = err_q;

endmodule

// File: tb/tb_ft600_fifo_model.sv
// Self-checking bench for the FT600 FIFO responder model. Words pushed
// into either buffer are queued as expectations and compared when they
// come out of the other side (bus read or host pop).
module tb_ft600_fifo_model;
    import ft600_fifo_model_pkg::*;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;

    typedef logic [BE_W+DATA_W-1:0] word_t;

    logic              iclk  = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_wr, host_rd;
    logic [DATA_W-1:0] host_data;
    logic [BE_W-1:0]   host_be;
    logic              host_full, host_empty;
    logic [DATA_W-1:0] host_data_o;
    logic [BE_W-1:0]   host_be_o;
    logic [AW:0]       rx_level, tx_level;
    logic [3:0]        err;

    logic              m_drive;
    logic [DATA_W-1:0] m_data;
    logic [BE_W-1:0]   m_be;
    wire  [DATA_W-1:0] io_data;
    wire  [BE_W-1:0]   io_be;

    assign io_data = m_drive ? m_data : {DATA_W{1'bz}};
    assign io_be   = m_drive ? m_be   : {BE_W{1'bz}};

    ft600_fifo_model_if bus_if ();

    ft600_fifo_model #(
        .DATA_W (DATA_W),
        .BE_W   (BE_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) dut (
        .iCLK        (iclk),
        .iRESET      (rst_n),
        .ft          (bus_if),
        .ioDATA      (io_data),
        .ioBE        (io_be),
        .iHOST_WR    (host_wr),
        .iHOST_DATA  (host_data),
        .iHOST_BE    (host_be),
        .oHOST_FULL  (host_full),
        .iHOST_RD    (host_rd),
        .oHOST_DATA  (host_data_o),
        .oHOST_BE    (host_be_o),
        .oHOST_EMPTY (host_empty),
        .oRX_LEVEL   (rx_level),
        .oTX_LEVEL   (tx_level),
        .oERR        (err)
    );

    always #5 iclk = ~iclk;

    word_t rx_q[$];
    word_t tx_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic host_push(input word_t w);
        host_wr = 1'b1;
        {host_be, host_data} = w;
        rx_q.push_back(w);
        tick();
        host_wr = 1'b0;
    endtask

    task automatic master_write(input word_t w, input bit accepted);
        m_drive = 1'b1;
        {m_be, m_data} = w;
        bus_if.iWR_N = 1'b0;
        if (accepted) tx_q.push_back(w);
        tick();
        bus_if.iWR_N = 1'b1;
        m_drive = 1'b0;
    endtask

    task automatic host_pop_check(input string tag);
        if (tx_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            check(tag, 64'({host_be_o, host_data_o}), 64'(tx_q.pop_front()));
        end
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
    endtask

    task automatic bus_read(input int n);
        bus_if.iOE_N = 1'b0;
        tick();
        tick();
        bus_if.iRD_N = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("bus_word", 64'({io_be, io_data}), 64'(rx_q.pop_front()));
            tick();
        end
        bus_if.iRD_N = 1'b1;
        bus_if.iOE_N = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.iOE_N = 1'b1;
        bus_if.iRD_N = 1'b1;
        bus_if.iWR_N = 1'b1;
        bus_if.iGPIO = 2'b00;
        host_wr = 1'b0;
        host_rd = 1'b0;
        host_data = '0;
        host_be = '0;
        m_drive = 1'b0;
        m_data = '0;
        m_be = '0;

        // Reset state.
        repeat (3) tick();
        check("rst_txe_n", 64'(bus_if.oTXE_N), 64'(1));
        check("rst_rxf_n", 64'(bus_if.oRXF_N), 64'(1));
        check("rst_bus_oe", 64'(dut.bus_oe), 64'(0));
        check("rst_rx_level", 64'(rx_level), 64'(0));
        check("rst_tx_level", 64'(tx_level), 64'(0));
        check("rst_host_empty", 64'(host_empty), 64'(1));
        check("rst_host_full", 64'(host_full), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        tick();
        check("post_rst_txe_n", 64'(bus_if.oTXE_N), 64'(0));
        check("post_rst_rxf_n", 64'(bus_if.oRXF_N), 64'(1));

        // Four-word read burst.
        for (int i = 1; i <= 4; i++) host_push({4'hF, {8{4'(i)}}});
        check("rx_level_4", 64'(rx_level), 64'(4));
        check("rxf_n_loaded", 64'(bus_if.oRXF_N), 64'(0));
        bus_if.iOE_N = 1'b0;
        tick();
        check("turn_no_drive", 64'(dut.bus_oe), 64'(0));
        tick();
        check("drive_on", 64'(dut.bus_oe), 64'(1));
        bus_if.iRD_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("burst_word", 64'({io_be, io_data}), 64'(rx_q.pop_front()));
            tick();
            check("burst_rxf_n", 64'(bus_if.oRXF_N), 64'(i == 3));
        end
        bus_if.iRD_N = 1'b1;
        bus_if.iOE_N = 1'b1;
        tick();
        check("burst_released", 64'(dut.bus_oe), 64'(0));
        check("burst_rx_level", 64'(rx_level), 64'(0));
        check("burst_err", 64'(err), 64'(0));

        // Fill the TX buffer, then overflow by one.
        for (int i = 0; i < DEPTH; i++) begin
            master_write({4'hF, 32'(i)}, 1'b1);
            if (i == DEPTH - 2) check("txe_n_one_left", 64'(bus_if.oTXE_N), 64'(0));
        end
        check("txe_n_full", 64'(bus_if.oTXE_N), 64'(1));
        check("tx_level_full", 64'(tx_level), 64'(DEPTH));
        check("fill_err", 64'(err), 64'(0));
        master_write({4'hF, 32'(DEPTH)}, 1'b0);
        check("overflow_err", 64'(err), 64'(4'b0001));
        check("overflow_level", 64'(tx_level), 64'(DEPTH));
        host_pop_check("tx_head_first");
        check("txe_n_freed", 64'(bus_if.oTXE_N), 64'(0));
        check("tx_level_freed", 64'(tx_level), 64'(DEPTH - 1));
        while (tx_q.size() > 0) host_pop_check("tx_drain");
        check("tx_drained_empty", 64'(host_empty), 64'(1));
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        check("pop_empty_level", 64'(tx_level), 64'(0));
        check("pop_empty_err", 64'(err), 64'(4'b0001));

        // Partial byte enables carried through to the host.
        master_write({4'b0011, 32'hDEAD_BEEF}, 1'b1);
        check("be_word_present", 64'(host_empty), 64'(0));
        host_pop_check("be_word");

        // Protocol errors: read while empty, write during OE.
        bus_if.iRD_N = 1'b0;
        tick();
        bus_if.iRD_N = 1'b1;
        check("rd_empty_err", 64'(err), 64'(4'b0011));
        check("rd_empty_level", 64'(rx_level), 64'(0));
        m_drive = 1'b1;
        m_data = 32'hBAD0_0001;
        m_be = 4'hF;
        bus_if.iWR_N = 1'b0;
        bus_if.iOE_N = 1'b0;
        tick();
        bus_if.iWR_N = 1'b1;
        bus_if.iOE_N = 1'b1;
        m_drive = 1'b0;
        check("wr_oe_err", 64'(err), 64'(4'b0111));
        check("wr_oe_no_push", 64'(tx_level), 64'(0));
        repeat (3) tick();
        check("err_sticky", 64'(err), 64'(4'b0111));
        check("err_state_idle", 64'(dut.state_q), 64'(S_IDLE));

        // Reset in the middle of a 16-word burst.
        for (int i = 0; i < 16; i++) host_push({4'hF, 32'h100 + 32'(i)});
        bus_if.iOE_N = 1'b0;
        tick();
        tick();
        bus_if.iRD_N = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("pre_rst_word", 64'({io_be, io_data}), 64'(rx_q.pop_front()));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bus_oe", 64'(dut.bus_oe), 64'(0));
        check("async_rxf_n", 64'(bus_if.oRXF_N), 64'(1));
        check("async_txe_n", 64'(bus_if.oTXE_N), 64'(1));
        check("async_rx_level", 64'(rx_level), 64'(0));
        check("async_err", 64'(err), 64'(0));
        rx_q.delete();
        bus_if.iRD_N = 1'b1;
        tick();
        tick();
        check("rst_hold_idle", 64'(dut.state_q), 64'(S_IDLE));
        bus_if.iOE_N = 1'b1;
        rst_n = 1'b1;
        tick();
        check("rel_idle", 64'(dut.state_q), 64'(S_IDLE));
        bus_if.iOE_N = 1'b0;
        tick();
        check("rel_turn", 64'(dut.state_q), 64'(S_TURN));
        bus_if.iOE_N = 1'b1;
        tick();
        check("rel_back_idle", 64'(dut.state_q), 64'(S_IDLE));

        // Illegal GPIO mode with both buffers holding data.
        host_push({4'hF, 32'h0000_0777});
        master_write({4'h5, 32'h0000_0888}, 1'b1);
        check("mode_pre_rxf_n", 64'(bus_if.oRXF_N), 64'(0));
        check("mode_pre_txe_n", 64'(bus_if.oTXE_N), 64'(0));
        bus_if.iGPIO = 2'b10;
        tick();
        check("mode_txe_n", 64'(bus_if.oTXE_N), 64'(1));
        check("mode_rxf_n", 64'(bus_if.oRXF_N), 64'(1));
        check("mode_err", 64'(err), 64'(4'b1000));
        check("mode_levels", 64'({rx_level, tx_level}), 64'({11'd1, 11'd1}));
        bus_if.iGPIO = 2'b00;
        tick();
        check("mode_clr_rxf_n", 64'(bus_if.oRXF_N), 64'(0));
        check("mode_clr_txe_n", 64'(bus_if.oTXE_N), 64'(0));
        check("mode_err_sticky", 64'(err), 64'(4'b1000));
        host_pop_check("mode_tx_word");
        bus_read(1);
        check("final_rx_level", 64'(rx_level), 64'(0));
        check("final_tx_level", 64'(tx_level), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
